// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle ARM controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [19:0] Instr_fields;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUCtrl;

  modport master (
    input  Instr_fields, ALUFlags,
    output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUCtrl
  );

  modport slave (
    output Instr_fields, ALUFlags,
    input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUCtrl
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: main FSM, ALU decoder, NZCV flags register
// and conditional-execution gating.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    Reset,
  multicycle_controller_if.master ctl
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_flags;
  logic        r_condex;

  logic [3:0]  w_cond;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic [3:0]  w_rd;
  logic        w_condcheck;
  logic [1:0]  w_aluctrl;
  logic        w_flags_we;
  logic        w_n, w_z, w_c, w_v;

  logic        w_pcw, w_rw, w_mw, w_irw, w_adr, w_sa;
  logic [1:0]  w_sb, w_rs, w_rg, w_im, w_al;

  assign w_cond  = ctl.Instr_fields[19:16];
  assign w_op    = ctl.Instr_fields[15:14];
  assign w_funct = ctl.Instr_fields[13:8];
  assign w_rd    = ctl.Instr_fields[3:0];
  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_condcheck = 1'b0;
    case (w_cond)
      4'b0000: w_condcheck = w_z;
      4'b0001: w_condcheck = ~w_z;
      4'b0010: w_condcheck = w_c;
      4'b0011: w_condcheck = ~w_c;
      4'b0100: w_condcheck = w_n;
      4'b0101: w_condcheck = ~w_n;
      4'b0110: w_condcheck = w_v;
      4'b0111: w_condcheck = ~w_v;
      4'b1000: w_condcheck = w_c & ~w_z;
      4'b1001: w_condcheck = ~w_c | w_z;
      4'b1010: w_condcheck = (w_n == w_v);
      4'b1011: w_condcheck = (w_n != w_v);
      4'b1100: w_condcheck = ~w_z & (w_n == w_v);
      4'b1101: w_condcheck = w_z | (w_n != w_v);
      4'b1110: w_condcheck = 1'b1;
      default: w_condcheck = 1'b0;
    endcase
  end

  always_comb begin
    w_aluctrl = 2'b00;
    case (w_funct[4:1])
      4'b0100: w_aluctrl = 2'b00;
      4'b0010: w_aluctrl = 2'b01;
      4'b0000: w_aluctrl = 2'b10;
      4'b1100: w_aluctrl = 2'b11;
      default: w_aluctrl = 2'b00;
    endcase
  end

  // CondEx was latched in DECODE, so a flags write here cannot gate this instruction
  assign w_flags_we = ((r_state == S_EXECR) || (r_state == S_EXECI)) &&
                      r_condex && w_funct[0];

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state  <= S_FETCH;
      r_flags  <= '0;
      r_condex <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_condex <= w_condcheck;
      if (w_flags_we) begin
        r_flags[3:2] <= ctl.ALUFlags[3:2];
        // logical ops leave carry and overflow untouched
        if (!w_aluctrl[1])
          r_flags[1:0] <= ctl.ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    w_pcw  = 1'b0;
    w_rw   = 1'b0;
    w_mw   = 1'b0;
    w_irw  = 1'b0;
    w_adr  = 1'b0;
    w_sa   = 1'b0;
    w_sb   = '0;
    w_rs   = '0;
    w_rg   = '0;
    w_im   = '0;
    w_al   = '0;
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: begin
        w_irw  = 1'b1;
        w_sa   = 1'b1;
        w_sb   = 2'b10;
        w_rs   = 2'b10;
        w_pcw  = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        w_sa = 1'b1;
        w_sb = 2'b10;
        w_rs = 2'b10;
        w_rg = {w_op == 2'b01, w_op == 2'b10};
        w_im = (w_op == 2'b00) ? 2'b00 : (w_op == 2'b01) ? 2'b01 : 2'b10;
        case (w_op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_sb   = 2'b01;
        w_im   = 2'b01;
        w_rg   = 2'b10;
        w_next = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr  = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_rs  = 2'b01;
        w_rw  = r_condex;
        w_pcw = r_condex & (w_rd == 4'd15);
      end
      S_MEMWRITE: begin
        w_adr = 1'b1;
        w_rg  = 2'b10;
        w_mw  = r_condex;
      end
      S_EXECR: begin
        w_al   = w_aluctrl;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        w_sb   = 2'b01;
        w_al   = w_aluctrl;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw  = r_condex;
        w_pcw = r_condex & (w_rd == 4'd15);
      end
      S_BRANCH: begin
        w_sb  = 2'b01;
        w_im  = 2'b10;
        w_rs  = 2'b10;
        w_pcw = r_condex;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign ctl.PCWrite   = w_pcw & ~Reset;
  assign ctl.RegWrite  = w_rw  & ~Reset;
  assign ctl.MemWrite  = w_mw  & ~Reset;
  assign ctl.IRWrite   = w_irw & ~Reset;
  assign ctl.AdrSrc    = w_adr;
  assign ctl.ALUSrcA   = w_sa;
  assign ctl.ALUSrcB   = w_sb;
  assign ctl.ResultSrc = w_rs;
  assign ctl.RegSrc    = w_rg;
  assign ctl.ImmSrc    = w_im;
  assign ctl.ALUCtrl   = w_al;
endmodule
